// File: rtl/decoder2_4_hold.sv
// rtl/decoder2_4_hold.sv - 2:4 decoder whose one-hot output is held for HOLD_CYCLES cycles
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous abort of the current hold (wins over in_valid)
//   in_valid   a1/a0 carry a code to decode
//   in_ready   high while idle; a code presented now is accepted at the edge
//   a1, a0     code bits, decoded index = 2*a0 + a1
//   y3..y0     registered one-hot decoded lines
//   out_valid  high while any y line is asserted
//   dec_cnt    count of accepted codes, wraps modulo 256

module decoder2_4_hold #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       a1,
  input  logic       a0,
  output logic       y3,
  output logic       y2,
  output logic       y1,
  output logic       y0,
  output logic       out_valid,
  output logic [7:0] dec_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Counter reload: the accepting edge itself is the first held cycle.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] y_q, y_d;
  logic [7:0] dec_cnt_q, dec_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      y_q       <= 4'd0;
      dec_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      y_q       <= y_d;
      dec_cnt_q <= dec_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    y_d       = y_q;
    dec_cnt_d = dec_cnt_q;
    if (clr) begin
      // Abort: drop the hold and refuse any code offered on this edge.
      state_d = IDLE;
      cnt_d   = 8'd0;
      y_d     = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // a0 is the high-weight bit, so {a0,a1} is the line index.
            y_d       = 4'b0001 << {a0, a1};
            cnt_d     = HOLD_LOAD;
            state_d   = HOLD;
            dec_cnt_d = dec_cnt_q + 8'd1;
          end
        end
        HOLD: begin
          if (cnt_q == 8'd0) begin
            y_d     = 4'd0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = IDLE;
          y_d     = 4'd0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign y3        = y_q[3];
  assign y2        = y_q[2];
  assign y1        = y_q[1];
  assign y0        = y_q[0];
  assign out_valid = |y_q;
  assign dec_cnt   = dec_cnt_q;

endmodule

// File: tb/tb_decoder2_4_hold.sv
// tb/tb_decoder2_4_hold.sv - self-checking bench for decoder2_4_hold (HOLD_CYCLES 4 and 1)

module tb_decoder2_4_hold;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       in_valid;
  logic       a1;
  logic       a0;

  logic [1:0] rdy;
  logic [1:0] ov;
  logic [3:0] y_h4;
  logic [3:0] y_h1;
  logic [7:0] dc_h4;
  logic [7:0] dc_h1;

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining held cycles (0 = idle), held line, accepted count.
  int hold_len [2] = '{4, 1};
  int rem      [2];
  int code     [2];
  int acc      [2];

  always #5 clk = ~clk;

  decoder2_4_hold #(.HOLD_CYCLES(4)) u_dut_h4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (rdy[0]),
    .a1       (a1),
    .a0       (a0),
    .y3       (y_h4[3]),
    .y2       (y_h4[2]),
    .y1       (y_h4[1]),
    .y0       (y_h4[0]),
    .out_valid(ov[0]),
    .dec_cnt  (dc_h4)
  );

  decoder2_4_hold #(.HOLD_CYCLES(1)) u_dut_h1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (rdy[1]),
    .a1       (a1),
    .a0       (a0),
    .y3       (y_h1[3]),
    .y2       (y_h1[2]),
    .y1       (y_h1[1]),
    .y0       (y_h1[0]),
    .out_valid(ov[1]),
    .dec_cnt  (dc_h1)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      rem[i]  = 0;
      code[i] = 0;
      acc[i]  = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rem[i] = 0; code[i] = 0; acc[i] = 0;
      end else if (clr) begin
        rem[i] = 0;
      end else if (rem[i] == 0) begin
        if (in_valid) begin
          rem[i]  = hold_len[i];
          code[i] = 2 * int'(a0) + int'(a1);
          acc[i]  = (acc[i] + 1) % 256;
        end
      end else begin
        rem[i] = rem[i] - 1;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] ey;
    for (int i = 0; i < 2; i++) begin
      ey = (rem[i] > 0) ? 4'(1 << code[i]) : 4'd0;
      check_val($sformatf("y[h%0d]", hold_len[i]), (i == 0) ? y_h4 : y_h1, ey);
      check_val($sformatf("out_valid[h%0d]", hold_len[i]), ov[i], (rem[i] > 0) ? 1 : 0);
      check_val($sformatf("in_ready[h%0d]", hold_len[i]), rdy[i], (rem[i] == 0) ? 1 : 0);
      check_val($sformatf("dec_cnt[h%0d]", hold_len[i]), (i == 0) ? dc_h4 : dc_h1, acc[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic v, input logic c, input logic b0, input logic b1);
    in_valid = v; clr = c; a0 = b0; a1 = b1;
  endtask

  // Assert reset a few ns after an edge, check it acts before the next edge, then release.
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 1'b1, 1'b1);
    model_reset();
    #3;
    check_all();
    step();
    rst_n = 1'b1;

    // Single code 10 (a0=1): y2 for 4 cycles on the HOLD=4 instance.
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step();
    check_val("single_dec_cnt", dc_h4, 32'd1);

    // All four codes back-to-back with in_valid held; pick the next code when idle.
    async_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (rem[0] == 0) {a0, a1} = 2'(acc[0]);
      step();
    end
    check_val("four_codes_dec_cnt", dc_h4, 32'd4);

    // clr in the second hold cycle with in_valid high.
    async_reset();
    set_in(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    step();
    set_in(1'b1, 1'b1, 1'b1, 1'b1);
    step();
    check_val("clr_y", y_h4, 32'd0);
    check_val("clr_dec_cnt", dc_h4, 32'd1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Code and in_valid wiggling during a hold must not disturb the held line.
    set_in(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      set_in(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step();
      check_val("hold_stable_y", y_h4, 32'd1);
    end
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Reset mid-hold, then 256 accepts on the HOLD=4 instance wrap dec_cnt to 0.
    set_in(1'b1, 1'b0, 1'b1, 1'b1);
    step();
    step();
    async_reset();
    for (int k = 0; k < 256 * 5; k++) begin
      {a0, a1} = 2'($urandom_range(0, 3));
      step();
    end
    check_val("wrap_dec_cnt", dc_h4, 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 1500; k++) begin
      set_in(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 19) == 0),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 199) == 0) async_reset();
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder2_4_hold.md
DECODER2_4_HOLD -- requirements
Module: decoder2_4_hold

Interface
- REQ-001: Parameter HOLD_CYCLES, default 4, number of cycles a decoded one-hot output is held; legal range 1..255.
- REQ-002: clk  input  1  single clock; all state updates on rising edge.
- REQ-003: rst_n  input  1  asynchronous active-low reset.
- REQ-004: clr  input  1  synchronous abort of the current hold.
- REQ-005: in_valid  input  1  a1/a0 carry a code to decode.
- REQ-006: in_ready  output  1  block can accept a code this cycle.
- REQ-007: a1  input  1  code bit, weight 1.
- REQ-008: a0  input  1  code bit, weight 2.
- REQ-009: y3, y2, y1, y0  output  1 each  registered one-hot decoded lines.
- REQ-010: out_valid  output  1  high while any y line is asserted.
- REQ-011: dec_cnt  output  8  count of accepted codes, wraps modulo 256.

Function
- REQ-012: Decoded index SHALL be 2*a0 + a1, so 00->y0, 01(a1=1)->y1, 10(a0=1)->y2, 11->y3; y3..y0 is the exact inverse of the team's 4:2 encoder (a0=y2|y3, a1=y1|y3).
- REQ-013: FSM SHALL have two states, IDLE and HOLD; in_ready = (state==IDLE), combinational from state only.
- REQ-014: Acceptance: at a rising edge with state==IDLE, in_valid=1, clr=0, the block SHALL latch {a0,a1}, drive the selected y line high, set out_valid=1, load hold counter with HOLD_CYCLES-1, enter HOLD, and increment dec_cnt.
- REQ-015: In HOLD, the counter SHALL decrement by 1 per cycle; at the edge where counter==0, y lines and out_valid SHALL clear to 0 and state SHALL return to IDLE.
- REQ-016: Latency: y/out_valid high from the accepting edge k to edge k+HOLD_CYCLES, i.e. exactly HOLD_CYCLES cycles; in_ready high again after edge k+HOLD_CYCLES.
- REQ-017: Throughput: at most one code per HOLD_CYCLES+1 cycles; in_valid while in HOLD SHALL be ignored (no latch, no count).
- REQ-018: At most one y line SHALL be high in any cycle; out_valid SHALL equal y3|y2|y1|y0.
- REQ-019: a1/a0 SHALL be sampled only at acceptance; changes during HOLD SHALL NOT affect y.
- REQ-020: HOLD_CYCLES=1: y high exactly one cycle; counter loads 0, return to IDLE at the next edge.
- REQ-021: clr=1 at an edge SHALL force IDLE, clear y and out_valid, and block acceptance that edge (clr wins over in_valid); dec_cnt SHALL be unaffected.
- REQ-022: dec_cnt SHALL wrap 255->0 without any flag.

Reset
- REQ-023: rst_n=0 SHALL immediately, independent of clk, force state IDLE, counter 0, y3..y0=0, out_valid=0, dec_cnt=0; in_ready=1 follows.
- REQ-024: Reset asserted mid-HOLD SHALL abort the hold; no pending code SHALL appear after release.
- REQ-025: First acceptance possible at the first rising edge with rst_n=1.

Verification
- REQ-026: HOLD_CYCLES=4, in_valid=1, a0=1,a1=0 one cycle -> y2=1 for 4 cycles, y3,y1,y0=0, in_ready=0 for 4 cycles, dec_cnt=1.
- REQ-027: All four codes 00,01,10,11 back-to-back with in_valid held -> y0,y1,y2,y3 each held 4 cycles, one idle cycle between, dec_cnt=4.
- REQ-028: HOLD_CYCLES=1, code 11 -> y3 high exactly 1 cycle; next code accepted 2 cycles after first.
- REQ-029: clr=1 in 2nd hold cycle with in_valid=1 -> outputs 0 next cycle, state IDLE, no new code accepted that edge, dec_cnt unchanged.
- REQ-030: rst_n low mid-HOLD asynchronously -> y=0, out_valid=0, dec_cnt=0 before next edge; 256 accepted codes -> dec_cnt=0.
- REQ-031: Code change on a1/a0 during HOLD and in_valid pulses during HOLD -> y unchanged, dec_cnt unchanged.
